// File: rtl/rarp_tx_ser.sv
// RARP packet serializer: captures the header fields on start and streams the
// big-endian packet as DATA_W-bit words under a valid/ready handshake.
module rarp_tx_ser #(
  parameter int DATA_W = 32,
  parameter bit PAD_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       hdr_type,
  input  logic [15:0]       proto_type,
  input  logic [7:0]        hdr_addr_length,
  input  logic [7:0]        pro_addr_length,
  input  logic [15:0]       operation,
  input  logic [47:0]       send_hdr_addr,
  input  logic [31:0]       send_ip_addr,
  input  logic [47:0]       target_hdr_addr,
  input  logic [31:0]       target_ip_addr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              input_hold,
  output logic [15:0]       pkt_count
);

  localparam int HDR_BITS  = 224;
  localparam int PKT_BYTES = PAD_EN ? 48 : 28;
  localparam int PKT_BITS  = PKT_BYTES * 8;
  localparam int NW        = PKT_BITS / DATA_W;
  localparam int IDX_W     = $clog2(NW);

  generate
    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_width
      $error("rarp_tx_ser: DATA_W must be 8, 16 or 32");
    end
  endgenerate

  // Field order of the packed struct is the on-wire big-endian byte order.
  typedef struct packed {
    logic [15:0] hdr_type;
    logic [15:0] proto_type;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] operation;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } rarp_hdr_t;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state, state_nxt;
  rarp_hdr_t           shadow;
  logic [IDX_W-1:0]    idx;
  logic [PKT_BITS-1:0] pkt_vec;
  logic [PKT_BITS-1:0] pkt_shift;
  logic [DATA_W-1:0]   cur_word;
  logic                at_last;

  generate
    if (PAD_EN) begin : g_pad
      assign pkt_vec = {shadow, {(PKT_BITS-HDR_BITS){1'b0}}};
    end else begin : g_nopad
      assign pkt_vec = shadow;
    end
  endgenerate

  // Current word is always the top slice once earlier words are shifted out.
  assign pkt_shift = pkt_vec << (idx * DATA_W);
  assign cur_word  = pkt_shift[PKT_BITS-1 -: DATA_W];
  assign at_last   = (idx == IDX_W'(NW-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)               state_nxt = SEND;
      SEND: if (tx_ready && at_last) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_valid   = 1'b0;
    input_hold = 1'b0;
    tx_last    = 1'b0;
    tx_data    = '0;
    if (state == SEND) begin
      tx_valid   = 1'b1;
      input_hold = 1'b1;
      tx_last    = at_last;
      tx_data    = cur_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      shadow    <= '0;
      pkt_count <= '0;
    end else if (state == IDLE) begin
      idx <= '0;
      if (start)
        shadow <= '{hdr_type, proto_type, hdr_addr_length, pro_addr_length,
                    operation, send_hdr_addr, send_ip_addr, target_hdr_addr,
                    target_ip_addr};
    end else if (tx_ready) begin
      if (at_last) pkt_count <= pkt_count + 16'd1;
      else         idx       <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_rarp_tx_ser.sv
// Bench for rarp_tx_ser: a byte-array model checks two configurations
// (32-bit unpadded, 8-bit padded) every cycle, plus directed literal checks.
module tb_rarp_tx_ser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, tx_ready;
  logic [15:0] hdr_type, proto_type, operation;
  logic [7:0]  hlen, plen;
  logic [47:0] sha, tha;
  logic [31:0] spa, tpa;

  logic [31:0] d32_data;
  logic        d32_valid, d32_last, d32_hold;
  logic [15:0] d32_cnt;
  logic [7:0]  d8_data;
  logic        d8_valid, d8_last, d8_hold;
  logic [15:0] d8_cnt;

  rarp_tx_ser #(.DATA_W(32), .PAD_EN(1'b0)) u_d32 (
    .clk(clk), .rst(rst), .start(start), .hdr_type(hdr_type), .proto_type(proto_type),
    .hdr_addr_length(hlen), .pro_addr_length(plen), .operation(operation),
    .send_hdr_addr(sha), .send_ip_addr(spa), .target_hdr_addr(tha), .target_ip_addr(tpa),
    .tx_data(d32_data), .tx_valid(d32_valid), .tx_ready(tx_ready), .tx_last(d32_last),
    .input_hold(d32_hold), .pkt_count(d32_cnt));

  rarp_tx_ser #(.DATA_W(8), .PAD_EN(1'b1)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .hdr_type(hdr_type), .proto_type(proto_type),
    .hdr_addr_length(hlen), .pro_addr_length(plen), .operation(operation),
    .send_hdr_addr(sha), .send_ip_addr(spa), .target_hdr_addr(tha), .target_ip_addr(tpa),
    .tx_data(d8_data), .tx_valid(d8_valid), .tx_ready(tx_ready), .tx_last(d8_last),
    .input_hold(d8_hold), .pkt_count(d8_cnt));

  int n_cmp = 0, n_err = 0;
  bit armed = 1'b0, preload = 1'b0, skip_cnt = 1'b0;

  // Model: instance 0 = 32-bit/28 bytes, instance 1 = 8-bit/48 bytes.
  bit          m_busy [2];
  int          m_ptr  [2];
  logic [15:0] m_cnt  [2];
  logic [7:0]  m_b    [2][48];

  function automatic int nw_of(int k); return (k == 0) ? 7 : 48; endfunction
  function automatic int nb_of(int k); return (k == 0) ? 4 : 1;  endfunction

  function automatic logic [31:0] exp_word(int k);
    logic [31:0] w = '0;
    for (int j = 0; j < nb_of(k); j++)
      w = (w << 8) | 32'(m_b[k][m_ptr[k]*nb_of(k) + j]);
    return w;
  endfunction

  localparam logic [47:0] BASE_SHA = 48'h02AA_BBCC_DD01;
  localparam logic [31:0] BASE_SPA = 32'hC0A8_0001;
  localparam logic [47:0] BASE_THA = 48'h0211_2233_4455;
  localparam logic [31:0] BASE_TPA = 32'h0A00_00FE;

  function automatic logic [31:0] ref_w32(int i);
    logic [223:0] f = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0003,
                       BASE_SHA, BASE_SPA, BASE_THA, BASE_TPA};
    return f[223 - 32*i -: 32];
  endfunction

  always @(posedge clk) begin
    logic [223:0] f;
    f = {hdr_type, proto_type, hlen, plen, operation, sha, spa, tha, tpa};
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0; m_ptr[k] <= 0; m_cnt[k] <= '0;
      end else if (m_busy[k]) begin
        if (tx_ready) begin
          if (m_ptr[k] == nw_of(k) - 1) begin
            m_busy[k] <= 1'b0; m_cnt[k] <= m_cnt[k] + 16'd1;
          end else m_ptr[k] <= m_ptr[k] + 1;
        end
      end else if (start) begin
        m_busy[k] <= 1'b1; m_ptr[k] <= 0;
        for (int i = 0; i < 48; i++)
          m_b[k][i] <= (i < 28) ? f[223 - 8*i -: 8] : 8'h00;
      end
    end
    if (preload) m_cnt[0] <= 16'hFFFF;
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  logic [31:0] acc32[$];
  logic [7:0]  acc8[$];
  int vc32, stall32, nlast32, last_at32, last_at8;

  always @(negedge clk) if (armed) begin
    for (int k = 0; k < 2; k++) begin
      logic        av, al, ah;
      logic [31:0] ad;
      logic [15:0] ac;
      av = (k == 0) ? d32_valid : d8_valid;
      al = (k == 0) ? d32_last  : d8_last;
      ah = (k == 0) ? d32_hold  : d8_hold;
      ad = (k == 0) ? d32_data  : {24'h0, d8_data};
      ac = (k == 0) ? d32_cnt   : d8_cnt;
      cmp($sformatf("valid[%0d]", k), {31'h0, av}, {31'h0, m_busy[k]});
      cmp($sformatf("hold[%0d]", k),  {31'h0, ah}, {31'h0, m_busy[k]});
      cmp($sformatf("last[%0d]", k),  {31'h0, al},
          {31'h0, m_busy[k] && (m_ptr[k] == nw_of(k) - 1)});
      cmp($sformatf("data[%0d]", k), ad, m_busy[k] ? exp_word(k) : 32'h0);
      if (!(skip_cnt && k == 0)) cmp($sformatf("count[%0d]", k), {16'h0, ac}, {16'h0, m_cnt[k]});
    end
    if (d32_valid) vc32++;
    if (d32_valid && !tx_ready) stall32++;
    if (d32_valid && tx_ready) begin
      acc32.push_back(d32_data);
      if (d32_last) begin nlast32++; last_at32 = acc32.size(); end
    end
    if (d8_valid && tx_ready) begin
      acc8.push_back(d8_data);
      if (d8_last) last_at8 = acc8.size();
    end
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic clr_log();
    acc32.delete(); acc8.delete();
    vc32 = 0; stall32 = 0; nlast32 = 0; last_at32 = -1; last_at8 = -1;
  endtask

  task automatic set_fields(bit basic);
    if (basic) begin
      hdr_type = 16'h0001; proto_type = 16'h0800; hlen = 8'h06; plen = 8'h04;
      operation = 16'h0003; sha = BASE_SHA; spa = BASE_SPA; tha = BASE_THA; tpa = BASE_TPA;
    end else begin
      hdr_type = 16'($urandom); proto_type = 16'($urandom); hlen = 8'($urandom);
      plen = 8'($urandom); operation = 16'($urandom);
      sha = {16'($urandom), $urandom}; spa = $urandom;
      tha = {16'($urandom), $urandom}; tpa = $urandom;
    end
  endtask

  task automatic pulse(); start = 1'b1; step(); start = 1'b0; endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!d32_valid && !d8_valid) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) cmp("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] orv;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    set_fields(0);
    clr_log();
    @(posedge clk); #1 armed = 1'b1;
    step(); step();
    cmp("rst_valid", {31'h0, d32_valid}, 32'h0);
    cmp("rst_count", {16'h0, d32_cnt}, 32'h0);
    cmp("rst_data8", {24'h0, d8_data}, 32'h0);
    rst = 1'b0;
    step();

    // Basic packet, ready held high
    clr_log(); set_fields(1); pulse(); wait_idle();
    cmp("basic_nwords", acc32.size(), 7);
    cmp("basic_w0", acc32[0], 32'h00010800);
    cmp("basic_w1", acc32[1], 32'h06040003);
    cmp("basic_w6", acc32[6], ref_w32(6));
    cmp("basic_vcycles", vc32, 7);
    cmp("basic_nlast", nlast32, 1);
    cmp("basic_last_at", last_at32, 7);
    cmp("basic_count", {16'h0, d32_cnt}, 32'h1);
    cmp("pad_nbytes", acc8.size(), 48);
    cmp("pad_b0", {24'h0, acc8[0]}, 32'h00);
    cmp("pad_b1", {24'h0, acc8[1]}, 32'h01);
    cmp("pad_b27", {24'h0, acc8[27]}, {24'h0, BASE_TPA[7:0]});
    orv = '0;
    for (int i = 28; i < 48; i++) orv |= acc8[i];
    cmp("pad_zero", {24'h0, orv}, 32'h0);
    cmp("pad_last_at", last_at8, 48);

    // Backpressure for three cycles on word 2
    clr_log(); set_fields(1); pulse();
    step(); step();
    tx_ready = 1'b0; step(); step(); step(); tx_ready = 1'b1;
    wait_idle();
    cmp("bp_vcycles", vc32, 10);
    cmp("bp_stall", stall32, 3);
    cmp("bp_nwords", acc32.size(), 7);
    for (int i = 0; i < 7; i++) cmp($sformatf("bp_w%0d", i), acc32[i], ref_w32(i));

    // Fields churn and start held during SEND, including the last-accept cycle
    clr_log(); set_fields(1); pulse();
    for (int i = 0; i < 7; i++) begin set_fields(0); start = 1'b1; step(); end
    start = 1'b0;
    cmp("no_requeue", {31'h0, d32_valid}, 32'h0);
    wait_idle();
    cmp("churn_nwords", acc32.size(), 7);
    for (int i = 0; i < 7; i++) cmp($sformatf("churn_w%0d", i), acc32[i], ref_w32(i));

    // Reset in the middle of a packet
    rst = 1'b1; step(); rst = 1'b0; step();
    clr_log(); set_fields(1); pulse();
    step(); step(); step();
    rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
    cmp("abort_valid", {31'h0, d32_valid}, 32'h0);
    cmp("abort_count", {16'h0, d32_cnt}, 32'h0);
    cmp("abort_nlast", nlast32, 0);
    step();
    clr_log(); set_fields(1); pulse(); wait_idle();
    cmp("after_rst_nwords", acc32.size(), 7);
    cmp("after_rst_w0", acc32[0], 32'h00010800);
    cmp("after_rst_count", {16'h0, d32_cnt}, 32'h1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_fields(0);
      start    = ($urandom_range(0, 3) == 0);
      tx_ready = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; tx_ready = 1'b1;
    wait_idle();

    // Counter wrap from 0xFFFF
    force u_d32.pkt_count = 16'hFFFF;
    preload = 1'b1; skip_cnt = 1'b1;
    step();
    release u_d32.pkt_count;
    preload = 1'b0; skip_cnt = 1'b0;
    step();
    cmp("preload_count", {16'h0, d32_cnt}, 32'hFFFF);
    clr_log(); set_fields(0); pulse(); wait_idle();
    cmp("wrap_count", {16'h0, d32_cnt}, 32'h0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
